// File: rtl/spi_cmd_sequencer_pkg.sv
// Shared opcodes, FSM encodings and status-byte layout for the SPI command sequencer.
package spi_cmd_sequencer_pkg;

   localparam logic [7:0] OP_NOP       = 8'h00;
   localparam logic [7:0] OP_WRITE_IMG = 8'h01;
   localparam logic [7:0] OP_READ_IMG  = 8'h02;
   localparam logic [7:0] OP_PROCESS   = 8'h03;
   localparam logic [7:0] OP_STATUS    = 8'h04;
   localparam logic [7:0] OP_ABORT     = 8'h05;
   localparam logic [7:0] OP_CLR_ERR   = 8'h06;

   typedef enum logic [3:0] {
      S_IDLE,
      S_WRITE,
      S_RD_ADDR,
      S_RD_WAIT,
      S_RD_PUSH,
      S_RD_GUARD,
      S_PROC,
      S_ST_PUSH
   } seq_state_e;

   typedef enum logic [1:0] {
      P_IDLE,
      P_WAIT,
      P_GUARD
   } push_state_e;

   localparam int STAT_READY_BIT = 0;
   localparam int STAT_BUSY_BIT  = 1;
   localparam int STAT_ERR_BIT   = 2;

   function automatic logic [7:0] status_byte(input logic err, input logic busy_prev);
      logic [7:0] b;
      b                 = 8'h00;
      b[STAT_READY_BIT] = 1'b1;
      b[STAT_BUSY_BIT]  = busy_prev;
      b[STAT_ERR_BIT]   = err;
      return b;
   endfunction

   function automatic logic is_known_op(input logic [7:0] op);
      return (op <= OP_CLR_ERR);
   endfunction

endpackage

// File: rtl/spi_cmd_sequencer_tx_byte_pusher.sv
// Holds one byte for the host return buffer, waits for tx_free, pulses tx_valid and
// then idles one guard cycle so the buffer's tx_free has time to fall.
module tx_byte_pusher
   import spi_cmd_sequencer_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   input  logic        load,
   input  logic [7:0]  load_data,
   input  logic        abort,
   input  logic        tx_free,
   output logic [7:0]  tx_data,
   output logic        tx_valid,
   output push_state_e dbg_state
);

   push_state_e p_state_q, p_state_d;
   logic [7:0]  byte_q, byte_d;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         p_state_q <= P_IDLE;
         byte_q    <= 8'h00;
      end else begin
         p_state_q <= p_state_d;
         byte_q    <= byte_d;
      end
   end

   always_comb begin
      p_state_d = p_state_q;
      byte_d    = byte_q;
      tx_valid  = 1'b0;
      tx_data   = 8'h00;
      case (p_state_q)
         P_WAIT: begin
            if (abort) begin
               p_state_d = P_IDLE;
            end else if (tx_free) begin
               tx_valid  = 1'b1;
               tx_data   = byte_q;
               p_state_d = P_GUARD;
            end
         end
         P_GUARD: p_state_d = P_IDLE;
         default: ;
      endcase
      // A load during the guard cycle is fine: tx_free is first sampled one cycle later.
      if (load) begin
         byte_d    = load_data;
         p_state_d = P_WAIT;
      end
   end

   assign dbg_state = p_state_q;

endmodule

// File: rtl/spi_cmd_sequencer.sv
// Decodes host command bytes and sequences image write, read-back and processing,
// owning the pixel memory port except while the engine holds it.
module spi_cmd_sequencer
   import spi_cmd_sequencer_pkg::*;
#(
   parameter int ADDR_W   = 12,
   parameter int IMG_SIZE = 4096
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [7:0]        in_cmd,
   input  logic              in_cmd_valid,
   input  logic [7:0]        in_data,
   input  logic              in_data_valid,
   output logic [7:0]        tx_data,
   output logic              tx_valid,
   input  logic              tx_free,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [7:0]        mem_wdata,
   output logic              mem_we,
   input  logic [7:0]        mem_rdata,
   output logic              proc_start,
   input  logic              proc_done,
   output logic              mem_grant_engine,
   output logic              busy,
   output logic              err,
   output seq_state_e        dbg_state,
   output push_state_e       dbg_push_state
);

   // Handshakes: in_cmd_valid, in_data_valid, tx_valid and proc_start/proc_done are
   // single-cycle strobes with no back-pressure; tx_free is the only flow control.
   localparam logic [ADDR_W:0] LAST_IDX = (ADDR_W+1)'(IMG_SIZE - 1);
   localparam logic [ADDR_W:0] CNT_ONE  = (ADDR_W+1)'(1);

   seq_state_e      state_q, state_d;
   logic [ADDR_W:0] cnt_q, cnt_d;
   logic            err_q, err_d;
   logic            pend_q, pend_d;
   logic            proc_start_q, proc_start_d;

   logic            busy_int;
   logic            cmd_status, cmd_clr, cmd_abort, cmd_bad_busy;
   logic            err_set, err_clr;
   logic            push_load, push_abort;
   logic [7:0]      push_data;
   logic            push_tx_valid;

   assign busy_int     = (state_q != S_IDLE);
   assign cmd_status   = in_cmd_valid && (in_cmd == OP_STATUS);
   assign cmd_clr      = in_cmd_valid && (in_cmd == OP_CLR_ERR);
   assign cmd_abort    = in_cmd_valid && (in_cmd == OP_ABORT) && busy_int && (state_q != S_PROC);
   assign cmd_bad_busy = in_cmd_valid && busy_int &&
                         !(in_cmd inside {OP_ABORT, OP_STATUS, OP_CLR_ERR});

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= S_IDLE;
         cnt_q        <= '0;
         err_q        <= 1'b0;
         pend_q       <= 1'b0;
         proc_start_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         err_q        <= err_d;
         pend_q       <= pend_d;
         proc_start_q <= proc_start_d;
      end
   end

   always_comb begin
      state_d      = state_q;
      cnt_d        = cnt_q;
      pend_d       = pend_q;
      proc_start_d = 1'b0;
      err_set      = 1'b0;
      err_clr      = 1'b0;
      mem_we       = 1'b0;
      mem_wdata    = 8'h00;
      push_load    = 1'b0;
      push_data    = 8'h00;
      push_abort   = 1'b0;

      case (state_q)
         S_IDLE: begin
            if (in_cmd_valid && (in_cmd == OP_WRITE_IMG)) begin
               cnt_d   = '0;
               state_d = S_WRITE;
            end else if (in_cmd_valid && (in_cmd == OP_READ_IMG)) begin
               cnt_d   = '0;
               state_d = S_RD_ADDR;
            end else if (in_cmd_valid && (in_cmd == OP_PROCESS)) begin
               proc_start_d = 1'b1;
               state_d      = S_PROC;
            end else if (cmd_status || pend_q) begin
               // A queued request reports that we were busy when it arrived.
               push_load = 1'b1;
               push_data = status_byte(err_q, pend_q && !cmd_status);
               pend_d    = 1'b0;
               state_d   = S_ST_PUSH;
            end
         end
         S_WRITE: begin
            if (in_data_valid) begin
               mem_we    = 1'b1;
               mem_wdata = in_data;
               if (cnt_q == LAST_IDX) state_d = S_IDLE;
               else                   cnt_d   = cnt_q + CNT_ONE;
            end
         end
         S_RD_ADDR: state_d = S_RD_WAIT;
         S_RD_WAIT: begin
            push_load = 1'b1;
            push_data = mem_rdata;
            state_d   = S_RD_PUSH;
         end
         S_RD_PUSH: if (push_tx_valid) state_d = S_RD_GUARD;
         S_RD_GUARD: begin
            if (cnt_q == LAST_IDX) begin
               state_d = S_IDLE;
            end else begin
               cnt_d   = cnt_q + CNT_ONE;
               state_d = S_RD_ADDR;
            end
         end
         S_PROC:    if (proc_done) state_d = S_IDLE;
         S_ST_PUSH: if (push_tx_valid) state_d = S_IDLE;
         default:   state_d = S_IDLE;
      endcase

      // Commands are evaluated after any same-cycle data byte has been written.
      if (in_data_valid && (state_q != S_WRITE)) err_set = 1'b1;
      if (in_cmd_valid && !is_known_op(in_cmd)) err_set = 1'b1;
      if (cmd_bad_busy) err_set = 1'b1;
      if (cmd_status && busy_int) pend_d = 1'b1;
      if (cmd_clr) err_clr = 1'b1;
      if (cmd_abort) begin
         state_d    = S_IDLE;
         push_abort = 1'b1;
         push_load  = 1'b0;
      end
      err_d = (err_q && !err_clr) || err_set;
   end

   tx_byte_pusher u_pusher (
      .clk       (clk),
      .rst       (rst),
      .load      (push_load),
      .load_data (push_data),
      .abort     (push_abort),
      .tx_free   (tx_free),
      .tx_data   (tx_data),
      .tx_valid  (push_tx_valid),
      .dbg_state (dbg_push_state)
   );

   assign tx_valid         = push_tx_valid;
   assign mem_addr         = cnt_q[ADDR_W-1:0];
   assign proc_start       = proc_start_q;
   assign mem_grant_engine = (state_q == S_PROC);
   assign busy             = busy_int;
   assign err              = err_q;
   assign dbg_state        = state_q;

endmodule

// File: tb/tb_spi_cmd_sequencer.sv
// Scenario bench for spi_cmd_sequencer with a small image, a synchronous pixel
// memory model and a return buffer that stays full for three cycles per byte.
module tb_spi_cmd_sequencer;
   import spi_cmd_sequencer_pkg::*;

   localparam int ADDR_W   = 4;
   localparam int IMG_SIZE = 16;

   logic              clk = 1'b0;
   logic              rst;
   logic [7:0]        in_cmd;
   logic              in_cmd_valid;
   logic [7:0]        in_data;
   logic              in_data_valid;
   logic [7:0]        tx_data;
   logic              tx_valid;
   logic              tx_free;
   logic [ADDR_W-1:0] mem_addr;
   logic [7:0]        mem_wdata;
   logic              mem_we;
   logic [7:0]        mem_rdata;
   logic              proc_start;
   logic              proc_done;
   logic              mem_grant_engine;
   logic              busy;
   logic              err;
   seq_state_e        dbg_state;
   push_state_e       dbg_push_state;

   int n_checks = 0;
   int n_fail   = 0;

   logic [11:0] exp_wr_q[$];
   logic [7:0]  exp_tx_q[$];
   logic [11:0] obs_wr_q[$];
   logic [7:0]  obs_tx_q[$];

   always #5 clk = ~clk;

   spi_cmd_sequencer #(.ADDR_W(ADDR_W), .IMG_SIZE(IMG_SIZE)) dut (
      .clk              (clk),
      .rst              (rst),
      .in_cmd           (in_cmd),
      .in_cmd_valid     (in_cmd_valid),
      .in_data          (in_data),
      .in_data_valid    (in_data_valid),
      .tx_data          (tx_data),
      .tx_valid         (tx_valid),
      .tx_free          (tx_free),
      .mem_addr         (mem_addr),
      .mem_wdata        (mem_wdata),
      .mem_we           (mem_we),
      .mem_rdata        (mem_rdata),
      .proc_start       (proc_start),
      .proc_done        (proc_done),
      .mem_grant_engine (mem_grant_engine),
      .busy             (busy),
      .err              (err),
      .dbg_state        (dbg_state),
      .dbg_push_state   (dbg_push_state)
   );

   // Pixel memory: read data valid one cycle after the address.
   logic [7:0] mem [0:IMG_SIZE-1];
   always @(posedge clk) begin
      if (mem_we) mem[mem_addr] <= mem_wdata;
      mem_rdata <= mem[mem_addr];
   end

   // Return buffer stays occupied for three cycles after each load.
   int hold = 0;
   always @(posedge clk) begin
      if (tx_valid)      hold <= 3;
      else if (hold > 0) hold <= hold - 1;
   end
   assign tx_free = (hold == 0);

   // Observation side of the scoreboard, sampled mid-cycle.
   int cyc = 0, last_tx_cyc = -100, gap_viol = 0, n_proc_start = 0, n_grant = 0;
   always @(negedge clk) begin
      cyc++;
      if (mem_we) obs_wr_q.push_back({mem_addr, mem_wdata});
      if (tx_valid) begin
         if (cyc - last_tx_cyc < 2) gap_viol++;
         last_tx_cyc = cyc;
         obs_tx_q.push_back(tx_data);
      end
      if (proc_start) n_proc_start++;
      if (mem_grant_engine) n_grant++;
   end

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic send_cmd(input logic [7:0] op);
      in_cmd       = op;
      in_cmd_valid = 1'b1;
      tick(1);
      in_cmd_valid = 1'b0;
      in_cmd       = 8'h00;
   endtask

   task automatic send_data(input logic [7:0] d);
      in_data       = d;
      in_data_valid = 1'b1;
      tick(1);
      in_data_valid = 1'b0;
      in_data       = 8'h00;
   endtask

   task automatic wait_idle(input int budget, output logic timed_out);
      int left;
      left = budget;
      while (busy && left > 0) begin
         tick(1);
         left--;
      end
      timed_out = busy;
   endtask

   task automatic write_pattern();
      send_cmd(OP_WRITE_IMG);
      for (int i = 0; i < IMG_SIZE; i++) begin
         send_data(8'(i) ^ 8'hA5);
         tick($urandom_range(0, 2));
      end
      tick(1);
      obs_wr_q.delete();
   endtask

   task automatic test_reset();
      rst = 1'b1;
      in_cmd = 8'h00; in_cmd_valid = 1'b0; in_data = 8'h00; in_data_valid = 1'b0;
      proc_done = 1'b0;
      tick(3);
      n_checks++;
      if ({tx_valid, mem_we, proc_start, mem_grant_engine, busy, err} !== 6'b0) begin
         n_fail++;
         $display("FAIL reset_ctrl got=%b exp=%b",
                  {tx_valid, mem_we, proc_start, mem_grant_engine, busy, err}, 6'b0);
      end
      n_checks++;
      if ({tx_data, mem_wdata, mem_addr} !== 20'h0) begin
         n_fail++;
         $display("FAIL reset_data got=%h exp=%h", {tx_data, mem_wdata, mem_addr}, 20'h0);
      end
      n_checks++;
      if (dbg_state !== S_IDLE) begin
         n_fail++;
         $display("FAIL reset_state got=%0d exp=%0d", dbg_state, S_IDLE);
      end
      rst = 1'b0;
      tick(2);
   endtask

   task automatic test_write();
      logic [11:0] e, g;
      send_cmd(OP_WRITE_IMG);
      for (int i = 0; i < IMG_SIZE; i++) begin
         if (i == IMG_SIZE - 1) begin
            n_checks++;
            if (busy !== 1'b1) begin
               n_fail++;
               $display("FAIL write_busy_before_last got=%b exp=1", busy);
            end
         end
         exp_wr_q.push_back({4'(i), 8'h10 + 8'(i)});
         send_data(8'h10 + 8'(i));
         tick($urandom_range(0, 2));
      end
      n_checks++;
      if ({busy, err} !== 2'b00) begin
         n_fail++;
         $display("FAIL write_done_busy_err got=%b exp=00", {busy, err});
      end
      while (exp_wr_q.size() > 0) begin
         e = exp_wr_q.pop_front();
         n_checks++;
         if (obs_wr_q.size() == 0) begin
            n_fail++;
            $display("FAIL write_missing got=none exp=%h", e);
         end else begin
            g = obs_wr_q.pop_front();
            if (g !== e) begin
               n_fail++;
               $display("FAIL write_addr_data got=%h exp=%h", g, e);
            end
         end
      end
      n_checks++;
      if (obs_wr_q.size() != 0) begin
         n_fail++;
         $display("FAIL write_extra got=%0d exp=0", obs_wr_q.size());
         obs_wr_q.delete();
      end
   endtask

   task automatic test_read();
      logic [7:0] e, g;
      logic       to;
      int         gv0;
      write_pattern();
      for (int i = 0; i < IMG_SIZE; i++) exp_tx_q.push_back(8'(i) ^ 8'hA5);
      gv0 = gap_viol;
      send_cmd(OP_READ_IMG);
      wait_idle(600, to);
      n_checks++;
      if (to) begin
         n_fail++;
         $display("FAIL read_timeout got=busy exp=idle");
      end
      while (exp_tx_q.size() > 0) begin
         e = exp_tx_q.pop_front();
         n_checks++;
         if (obs_tx_q.size() == 0) begin
            n_fail++;
            $display("FAIL read_missing got=none exp=%h", e);
         end else begin
            g = obs_tx_q.pop_front();
            if (g !== e) begin
               n_fail++;
               $display("FAIL read_byte got=%h exp=%h", g, e);
            end
         end
      end
      n_checks++;
      if (obs_tx_q.size() != 0) begin
         n_fail++;
         $display("FAIL read_extra got=%0d exp=0", obs_tx_q.size());
         obs_tx_q.delete();
      end
      n_checks++;
      if (gap_viol != gv0) begin
         n_fail++;
         $display("FAIL read_tx_gap got=%0d exp=%0d", gap_viol, gv0);
      end
   endtask

   task automatic test_process();
      int ps0, gr0;
      ps0 = n_proc_start;
      gr0 = n_grant;
      send_cmd(OP_PROCESS);
      n_checks++;
      if ({proc_start, mem_grant_engine, busy} !== 3'b111) begin
         n_fail++;
         $display("FAIL proc_entry got=%b exp=111", {proc_start, mem_grant_engine, busy});
      end
      tick(1);
      send_cmd(OP_PROCESS);
      tick(17);
      proc_done = 1'b1;
      tick(1);
      proc_done = 1'b0;
      n_checks++;
      if (n_proc_start - ps0 != 1) begin
         n_fail++;
         $display("FAIL proc_start_count got=%0d exp=1", n_proc_start - ps0);
      end
      n_checks++;
      if (n_grant - gr0 != 20) begin
         n_fail++;
         $display("FAIL grant_cycles got=%0d exp=20", n_grant - gr0);
      end
      n_checks++;
      if ({busy, mem_grant_engine, err} !== 3'b001) begin
         n_fail++;
         $display("FAIL proc_exit got=%b exp=001", {busy, mem_grant_engine, err});
      end
      proc_done = 1'b1;
      tick(1);
      proc_done = 1'b0;
      tick(1);
      n_checks++;
      if ({busy, mem_grant_engine, proc_start} !== 3'b000) begin
         n_fail++;
         $display("FAIL stray_done got=%b exp=000", {busy, mem_grant_engine, proc_start});
      end
   endtask

   task automatic test_abort();
      logic [11:0] e, g;
      logic [7:0]  d;
      send_cmd(OP_CLR_ERR);
      n_checks++;
      if (err !== 1'b0) begin
         n_fail++;
         $display("FAIL clr_err got=%b exp=0", err);
      end
      send_cmd(OP_WRITE_IMG);
      for (int i = 0; i < 5; i++) begin
         d = 8'($urandom_range(0, 255));
         exp_wr_q.push_back({4'(i), d});
         send_data(d);
      end
      send_cmd(OP_ABORT);
      n_checks++;
      if ({busy, err} !== 2'b00 || dbg_state !== S_IDLE) begin
         n_fail++;
         $display("FAIL abort_idle got=%b/%0d exp=00/%0d", {busy, err}, dbg_state, S_IDLE);
      end
      for (int i = 0; i < 3; i++) begin
         send_data(8'($urandom_range(0, 255)));
         tick(1);
      end
      while (exp_wr_q.size() > 0) begin
         e = exp_wr_q.pop_front();
         n_checks++;
         if (obs_wr_q.size() == 0) begin
            n_fail++;
            $display("FAIL abort_write_missing got=none exp=%h", e);
         end else begin
            g = obs_wr_q.pop_front();
            if (g !== e) begin
               n_fail++;
               $display("FAIL abort_write got=%h exp=%h", g, e);
            end
         end
      end
      n_checks++;
      if (obs_wr_q.size() != 0) begin
         n_fail++;
         $display("FAIL abort_write_extra got=%0d exp=0", obs_wr_q.size());
         obs_wr_q.delete();
      end
      n_checks++;
      if (err !== 1'b1) begin
         n_fail++;
         $display("FAIL stray_data_err got=%b exp=1", err);
      end
   endtask

   task automatic test_status();
      logic [7:0] e, g;
      exp_tx_q.push_back(8'h05);
      send_cmd(OP_STATUS);
      tick(6);
      send_cmd(OP_CLR_ERR);
      exp_tx_q.push_back(8'h01);
      send_cmd(OP_STATUS);
      tick(6);
      send_cmd(OP_WRITE_IMG);
      send_cmd(OP_STATUS);
      n_checks++;
      if ({busy, err} !== 2'b10) begin
         n_fail++;
         $display("FAIL status_while_busy got=%b exp=10", {busy, err});
      end
      exp_tx_q.push_back(8'h03);
      send_cmd(OP_ABORT);
      tick(8);
      while (exp_tx_q.size() > 0) begin
         e = exp_tx_q.pop_front();
         n_checks++;
         if (obs_tx_q.size() == 0) begin
            n_fail++;
            $display("FAIL status_missing got=none exp=%h", e);
         end else begin
            g = obs_tx_q.pop_front();
            if (g !== e) begin
               n_fail++;
               $display("FAIL status_byte got=%h exp=%h", g, e);
            end
         end
      end
      n_checks++;
      if (obs_tx_q.size() != 0 || busy !== 1'b0) begin
         n_fail++;
         $display("FAIL status_extra got=%0d/%b exp=0/0", obs_tx_q.size(), busy);
         obs_tx_q.delete();
      end
   endtask

   task automatic test_reset_mid_read();
      logic [7:0] e, g;
      logic       to;
      int         left;
      write_pattern();
      for (int i = 0; i < 7; i++) exp_tx_q.push_back(8'(i) ^ 8'hA5);
      send_cmd(OP_READ_IMG);
      left = 300;
      while (obs_tx_q.size() < 7 && left > 0) begin
         @(negedge clk);
         #1;
         left--;
      end
      n_checks++;
      if (obs_tx_q.size() < 7) begin
         n_fail++;
         $display("FAIL midread_timeout got=%0d exp=7", obs_tx_q.size());
      end
      rst = 1'b1;
      #1;
      n_checks++;
      if ({tx_valid, mem_we, proc_start, busy} !== 4'b0000) begin
         n_fail++;
         $display("FAIL midread_reset got=%b exp=0000", {tx_valid, mem_we, proc_start, busy});
      end
      while (exp_tx_q.size() > 0) begin
         e = exp_tx_q.pop_front();
         n_checks++;
         if (obs_tx_q.size() == 0) begin
            n_fail++;
            $display("FAIL midread_missing got=none exp=%h", e);
         end else begin
            g = obs_tx_q.pop_front();
            if (g !== e) begin
               n_fail++;
               $display("FAIL midread_byte got=%h exp=%h", g, e);
            end
         end
      end
      tick(2);
      rst = 1'b0;
      tick(40);
      n_checks++;
      if (obs_tx_q.size() != 0 || busy !== 1'b0) begin
         n_fail++;
         $display("FAIL post_reset_quiet got=%0d/%b exp=0/0", obs_tx_q.size(), busy);
         obs_tx_q.delete();
      end
      for (int i = 0; i < IMG_SIZE; i++) exp_tx_q.push_back(8'(i) ^ 8'hA5);
      send_cmd(OP_READ_IMG);
      wait_idle(600, to);
      n_checks++;
      if (to) begin
         n_fail++;
         $display("FAIL reread_timeout got=busy exp=idle");
      end
      while (exp_tx_q.size() > 0) begin
         e = exp_tx_q.pop_front();
         n_checks++;
         if (obs_tx_q.size() == 0) begin
            n_fail++;
            $display("FAIL reread_missing got=none exp=%h", e);
         end else begin
            g = obs_tx_q.pop_front();
            if (g !== e) begin
               n_fail++;
               $display("FAIL reread_byte got=%h exp=%h", g, e);
            end
         end
      end
      n_checks++;
      if (obs_tx_q.size() != 0) begin
         n_fail++;
         $display("FAIL reread_extra got=%0d exp=0", obs_tx_q.size());
         obs_tx_q.delete();
      end
   endtask

   initial begin
      test_reset();
      test_write();
      test_read();
      test_process();
      test_abort();
      test_status();
      test_reset_mid_read();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
